instr_encoder_loader: RTL and testbench

Program loader for the single-cycle RISC-V core. It accepts one symbolic instruction per handshake (operation select plus register and immediate fields) and encodes it into a 32-bit RV32I word. It then writes that word into instruction memory at sequential addresses starting at 0. It produces exactly the opcode, funct3 and funct7 patterns that the core's control and ALU-control decoders consume: lw, sw, sub, xor, srl, addi, beq.

---
 rtl/instr_encoder_loader.sv | 136 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic RV32I instructions (lw, sw, sub, xor,
// srl, addi, beq) and writes them into instruction memory from address 0 upward.
// Optional macro CHECK_IMM_EN: reject out-of-range immediates and odd beq offsets.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         word_q, word_d;
  logic                last_q, last_d;
  logic                error_q, error_d;

  logic [31:0]         enc_word;
  logic                enc_ok;

  // Encode the presented fields and decide whether the instruction is acceptable.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    case (in_op)
      3'd0:    enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      3'd1:    enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      3'd2:    enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      3'd3:    enc_word = {7'b0000000, in_rs2, in_rs1, 3'b100, in_rd, 7'b0110011};
      3'd4:    enc_word = {7'b0000000, in_rs2, in_rs1, 3'b101, in_rd, 7'b0110011};
      3'd5:    enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      3'd6:    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                           in_imm[4:1], in_imm[11], 7'b1100011};
      default: enc_ok = 1'b0;
    endcase
`ifdef CHECK_IMM_EN
    // 12-bit immediates must be sign-extendable; branch offsets must be even.
    if ((in_op == 3'd0 || in_op == 3'd1 || in_op == 3'd5) && (in_imm[12] != in_imm[11])) begin
      enc_ok = 1'b0;
    end
    if (in_op == 3'd6 && in_imm[0]) begin
      enc_ok = 1'b0;
    end
`endif
  end

`ifndef CHECK_IMM_EN
  // Branch offset bit 0 is dropped when immediates are not checked.
  logic unused_imm0;
  assign unused_imm0 = in_imm[0];
`endif

  // Next-state logic for the load sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    error_d = error_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (enc_ok) begin
            word_d  = enc_word;
            last_d  = in_last;
            state_d = StWrite;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
        // Writing the top word means memory is full.
        state_d = (last_q || (&addr_q)) ? StDone : StIdle;
      end
      StDone: begin
        if (restart) begin
          state_d = StIdle;
          addr_d  = '0;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      error_q <= error_d;
    end
  end

  // in_ready is masked during reset so it is low even before the state settles.
  assign in_ready  = (state_q == StIdle) && !reset;
  assign mem_we    = (state_q == StWrite);
  assign done      = (state_q == StDone);
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign count     = count_q;
  assign error     = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes are queued by the
// stimulus and popped by per-instance monitors whenever mem_we is seen.
module tb_instr_encoder_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, restart, in_last;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;

  logic        valid1, ready1, we1, done1, err1;
  logic [4:0]  addr1;
  logic [31:0] wdata1;
  logic [5:0]  count1;

  logic        valid2, ready2, we2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  count2;

  instr_encoder_loader #(.ADDR_W(5)) dut1 (
    .clock(clock), .reset(reset), .in_valid(valid1), .in_ready(ready1), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .restart(restart), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .done(done1),
    .error(err1), .count(count1)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(valid2), .in_ready(ready2), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .restart(1'b0), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .done(done2),
    .error(err2), .count(count2)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the 32-word instance.
  always @(negedge clock) begin
    if (we1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected write: addr %0d data 0x%08h, expected none", addr1, wdata1);
      end else begin
        e1 = q1.pop_front();
        check("dut1 mem_addr", 32'(addr1), 32'(e1.addr));
        check("dut1 mem_wdata", wdata1, e1.data);
      end
    end
  end

  // Monitor for the 4-word instance.
  always @(negedge clock) begin
    if (we2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2 unexpected write: addr %0d data 0x%08h, expected none", addr2, wdata2);
      end else begin
        e2 = q2.pop_front();
        check("dut2 mem_addr", 32'(addr2), 32'(e2.addr));
        check("dut2 mem_wdata", wdata2, e2.data);
      end
    end
  end

  task automatic send(input bit sel, input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                      input logic last, input bit wr, input logic [4:0] ea,
                      input logic [31:0] ed);
    exp_t t;
    int   k;
    t.addr = ea;
    t.data = ed;
    if (wr) begin
      if (sel) q2.push_back(t);
      else     q1.push_back(t);
    end
    @(negedge clock);
    in_op   = op;
    in_rd   = rd;
    in_rs1  = rs1;
    in_rs2  = rs2;
    in_imm  = imm;
    in_last = last;
    if (sel) valid2 = 1'b1;
    else     valid1 = 1'b1;
    k = 0;
    while (((sel ? ready2 : ready1) !== 1'b1) && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake timeout: in_ready 0 for 20 cycles, expected 1");
    end
    @(posedge clock);
    #1;
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("in_ready during reset", 32'(ready1), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("reset in_ready", 32'(ready1), 32'd1);
    check("reset mem_we", 32'(we1), 32'd0);
    check("reset mem_addr", 32'(addr1), 32'd0);
    check("reset mem_wdata", wdata1, 32'd0);
    check("reset done", 32'(done1), 32'd0);
    check("reset error", 32'(err1), 32'd0);
    check("reset count", 32'(count1), 32'd0);

    // addi x1,x0,5: write appears in the cycle after accept
    send(0, 3'd5, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, 1, 5'd0, 32'h00500093);
    @(negedge clock);
    check("mem_we after accept", 32'(we1), 32'd1);
    check("in_ready in write", 32'(ready1), 32'd0);
    @(negedge clock);
    check("count after addi", 32'(count1), 32'd1);
    check("in_ready after write", 32'(ready1), 32'd1);

    send(0, 3'd0, 5'd2, 5'd1, 5'd0, 13'd8, 1'b0, 1, 5'd1, 32'h0080A103);   // lw x2,8(x1)
    send(0, 3'd1, 5'd0, 5'd1, 5'd2, 13'd4, 1'b0, 1, 5'd2, 32'h0020A223);   // sw x2,4(x1)
    send(0, 3'd2, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1, 5'd3, 32'h402081B3);   // sub x3,x1,x2

    // Invalid op: handshake completes, nothing written, error sticks
    send(0, 3'd7, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 0, 5'd0, 32'd0);
    @(negedge clock);
    check("error after op7", 32'(err1), 32'd1);
    check("in_ready after op7", 32'(ready1), 32'd1);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check("error kept, restart outside DONE", 32'(err1), 32'd1);
    check("count before beq", 32'(count1), 32'd4);

    // beq x1,x2,-8 as last instruction
    send(0, 3'd6, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 1, 5'd4, 32'hFE208CE3);
    @(negedge clock);
    @(negedge clock);
    check("done after last", 32'(done1), 32'd1);
    check("in_ready in DONE", 32'(ready1), 32'd0);
    check("count after last", 32'(count1), 32'd5);

    // Inputs ignored in DONE
    in_op = 3'd5; valid1 = 1'b1;
    repeat (2) @(negedge clock);
    valid1 = 1'b0;
    check("done held", 32'(done1), 32'd1);
    check("count held in DONE", 32'(count1), 32'd5);

    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check("restart done", 32'(done1), 32'd0);
    check("restart count", 32'(count1), 32'd0);
    check("restart error", 32'(err1), 32'd0);
    check("restart mem_addr", 32'(addr1), 32'd0);
    check("restart in_ready", 32'(ready1), 32'd1);

    send(0, 3'd5, 5'd5, 5'd1, 5'd0, 13'h1FFF, 1'b0, 1, 5'd0, 32'hFFF08293); // addi x5,x1,-1
    send(0, 3'd3, 5'd4, 5'd1, 5'd2, 13'd0, 1'b0, 1, 5'd1, 32'h0020C233);    // xor x4,x1,x2
    send(0, 3'd4, 5'd5, 5'd1, 5'd2, 13'd0, 1'b0, 1, 5'd2, 32'h0020D2B3);    // srl x5,x1,x2

`ifdef CHECK_IMM_EN
    send(0, 3'd5, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b0, 0, 5'd0, 32'd0);
    @(negedge clock);
    check("imm range error", 32'(err1), 32'd1);
    send(0, 3'd2, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1, 5'd3, 32'h402081B3);
`else
    send(0, 3'd5, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b0, 1, 5'd3, 32'h80000093);
    @(negedge clock);
    check("no error on truncated imm", 32'(err1), 32'd0);
    send(0, 3'd2, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1, 5'd4, 32'h402081B3);
`endif
    // Reset raised during the WRITE cycle
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("mem_we after mid-write reset", 32'(we1), 32'd0);
    check("count after mid-write reset", 32'(count1), 32'd0);
    check("mem_addr after mid-write reset", 32'(addr1), 32'd0);
    check("mem_wdata after mid-write reset", wdata1, 32'd0);
    check("in_ready while reset held", 32'(ready1), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("in_ready after reset release", 32'(ready1), 32'd1);
    check("mem_we idle after reset", 32'(we1), 32'd0);

    // Memory-full termination on the 4-word instance
    for (int k = 1; k <= 4; k++) begin
      send(1, 3'd5, 5'd1, 5'd0, 5'd0, 13'(k), 1'b0, 1, 5'(k - 1),
           {12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011});
    end
    @(negedge clock);
    @(negedge clock);
    check("dut2 done when full", 32'(done2), 32'd1);
    check("dut2 count when full", 32'(count2), 32'd4);
    check("dut2 in_ready when full", 32'(ready2), 32'd0);

    repeat (3) @(negedge clock);
    check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
    check("dut2 scoreboard drained", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
